execute_pipe: RTL and testbench
===============================

EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of data, PC and ALU result fields.
REQ-002 Parameter INSTRUCTION, default 32, width of the instruction field.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  execute stage presents a valid payload.
REQ-006 in_ready  out  1  execute_pipe can accept a payload this cycle.
REQ-007 flush  in  1  discard all held payloads (branch/jump redirect).
REQ-008 alu_result, store_data, pc  in  DATA_WIDTH each  execute-stage payload data.
REQ-009 instruction  in  INSTRUCTION  payload instruction word.
REQ-010 Load, Store, mem_en, reg_write  in  1 each  payload control bits.
REQ-011 mem_to_reg  in  2  payload writeback select.
REQ-012 out_valid  out  1  memory stage sees a valid payload.
REQ-013 mem_ready  in  1  memory stage accepts the presented payload.
REQ-014 alu_result_execute_pp, store_data_execute_pp, pc_execute_pp, instruction_execute_pp, Load_execute_pp, Store_execute_pp, mem_en_execute_pp, execute_reg_write_pp, mem_to_reg_execute_pp  out  matching input widths  head payload.
REQ-015 stall_count  out  16  number of cycles with out_valid=1 and mem_ready=0.

Function
REQ-016 Two-entry in-order skid buffer; states EMPTY (0 held), ONE (1 held), TWO (2 held).
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; it depends on registered state only.
REQ-018 Accept = in_valid & in_ready; release = out_valid & mem_ready.
REQ-019 out_valid SHALL be 1 in ONE and TWO and 0 in EMPTY.
REQ-020 Latency: a payload accepted in cycle N SHALL appear at the outputs with out_valid=1 in cycle N+1 when the buffer was EMPTY.
REQ-021 Transitions: EMPTY -accept-> ONE; ONE -accept&~release-> TWO; ONE -release&~accept-> EMPTY; ONE -accept&release-> ONE (new payload at head); TWO -release-> ONE; all other cases hold.
REQ-022 Payloads SHALL leave in acceptance order; no payload is dropped or duplicated without flush.
REQ-023 Head payload SHALL remain stable while out_valid=1 and mem_ready=0.
REQ-024 When out_valid=0, Load, Store, mem_en and execute_reg_write_pp outputs SHALL be 0 (bubble); data outputs hold their last value.
REQ-025 flush SHALL move state to EMPTY on the next edge, invalidate both entries and suppress any same-cycle accept; flush has priority over accept and release.
REQ-026 stall_count SHALL increment by 1 per stalled cycle, saturate at 16'hFFFF, and not change on flush.

Reset
REQ-027 While rst=0: state EMPTY, out_valid=0, in_ready=1, all control outputs 0, all data outputs 0, stall_count 0.
REQ-028 Reset asserted mid-transfer SHALL discard all held payloads immediately, without waiting for a clock edge.
REQ-029 First accept is possible on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package rv32i_pipe_pkg SHALL hold the state enum (EMPTY/ONE/TWO) and the execute payload struct type.
REQ-031 The two-entry buffer SHALL be a sub-module pipe_skid_buffer, parameterised on payload width; execute_pipe adds bubble masking, flush and stall_count.

Verification
REQ-032 Reset then in_valid=1 with alu_result=32'h0000_0010, mem_ready=1 -> next cycle out_valid=1, alu_result_execute_pp=32'h10, in_ready=1.
REQ-033 mem_ready=0, push A=1, B=2 -> state TWO, in_ready=0, head=1; third push C=3 not accepted; mem_ready=1 for 2 cycles -> outputs 1 then 2.
REQ-034 Full buffer plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, reg_write/mem_en outputs 0, stall_count unchanged.
REQ-035 ONE state, accept and release same cycle with in alu_result=32'h55 -> state stays ONE, head=32'h55.
REQ-036 mem_ready=0 with out_valid=1 for 70000 cycles -> stall_count=16'hFFFF, no wrap.
REQ-037 rst=0 asserted mid-cycle while TWO -> out_valid drops to 0 before next clock edge, all outputs 0.

Source files
------------

// File: rtl/rv32i_pipe_pkg.sv
// rv32i_pipe_pkg: shared types for the execute-to-memory pipeline register.
package rv32i_pipe_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
    typedef struct packed {
        logic       load;
        logic       store;
        logic       mem_en;
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } ex_ctrl_t;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;
endpackage

// File: rtl/execute_pipe_if.sv
// execute_pipe_if: execute-stage payload in, memory-stage payload out.
interface execute_pipe_if #(parameter int DATA_WIDTH = 32, parameter int INSTRUCTION = 32);
    logic                   in_valid, in_ready, flush, mem_ready, out_valid;
    logic [DATA_WIDTH-1:0]  alu_result, store_data, pc;
    logic [INSTRUCTION-1:0] instruction;
    logic                   Load, Store, mem_en, reg_write;
    logic [1:0]             mem_to_reg;
    logic [DATA_WIDTH-1:0]  alu_result_execute_pp, store_data_execute_pp, pc_execute_pp;
    logic [INSTRUCTION-1:0] instruction_execute_pp;
    logic                   Load_execute_pp, Store_execute_pp, mem_en_execute_pp, execute_reg_write_pp;
    logic [1:0]             mem_to_reg_execute_pp;
    logic [15:0]            stall_count;
    modport slave (
        input  in_valid, flush, mem_ready, alu_result, store_data, pc, instruction,
               Load, Store, mem_en, reg_write, mem_to_reg,
        output in_ready, out_valid, alu_result_execute_pp, store_data_execute_pp, pc_execute_pp,
               instruction_execute_pp, Load_execute_pp, Store_execute_pp, mem_en_execute_pp,
               execute_reg_write_pp, mem_to_reg_execute_pp, stall_count
    );
    modport master (
        output in_valid, flush, mem_ready, alu_result, store_data, pc, instruction,
               Load, Store, mem_en, reg_write, mem_to_reg,
        input  in_ready, out_valid, alu_result_execute_pp, store_data_execute_pp, pc_execute_pp,
               instruction_execute_pp, Load_execute_pp, Store_execute_pp, mem_en_execute_pp,
               execute_reg_write_pp, mem_to_reg_execute_pp, stall_count
    );
endinterface

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry in-order skid buffer with flush.
module pipe_skid_buffer
    import rv32i_pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    skid_state_e  state, nxt;
    logic [W-1:0] tail;
    logic         acc, rel;
    assign in_ready  = state != TWO;
    assign out_valid = state != EMPTY;
    assign acc = in_valid & in_ready & ~flush;
    assign rel = out_valid & out_ready & ~flush;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= EMPTY;
        else state <= nxt;
    always_comb begin
        nxt = state;
        nxt = flush ? EMPTY :
              state == EMPTY ? (acc ? ONE : EMPTY) :
              state == ONE ? (acc == rel ? ONE : (acc ? TWO : EMPTY)) :
              (rel ? ONE : TWO);
    end
    // head is never cleared on release so data outputs hold through bubbles
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out_data <= '0;
            tail     <= '0;
        end else if (!flush) begin
            if (acc && (state == EMPTY || rel)) out_data <= in_data;
            else if (rel && state == TWO) out_data <= tail;
            if (acc && state == ONE && !rel) tail <= in_data;
        end
endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: execute-to-memory pipeline register with skid buffering,
// bubble masking of control bits, flush and a saturating stall counter.
module execute_pipe
    import rv32i_pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTRUCTION = 32
) (
    input logic           clk,
    input logic           rst,
    execute_pipe_if.slave bus
);
    localparam int W = 3 * DATA_WIDTH + INSTRUCTION + $bits(ex_ctrl_t);
    ex_ctrl_t     in_ctrl, hd_ctrl;
    logic [W-1:0] in_data, hd;
    logic         valid;
    logic [15:0]  stall;
    assign in_ctrl = '{bus.Load, bus.Store, bus.mem_en, bus.reg_write, bus.mem_to_reg};
    assign in_data = {in_ctrl, bus.alu_result, bus.store_data, bus.pc, bus.instruction};
    pipe_skid_buffer #(.W(W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .in_valid (bus.in_valid),
        .in_data  (in_data),
        .in_ready (bus.in_ready),
        .out_valid(valid),
        .out_data (hd),
        .out_ready(bus.mem_ready)
    );
    assign {hd_ctrl, bus.alu_result_execute_pp, bus.store_data_execute_pp,
            bus.pc_execute_pp, bus.instruction_execute_pp} = hd;
    assign bus.out_valid             = valid;
    assign bus.Load_execute_pp       = valid & hd_ctrl.load;
    assign bus.Store_execute_pp      = valid & hd_ctrl.store;
    assign bus.mem_en_execute_pp     = valid & hd_ctrl.mem_en;
    assign bus.execute_reg_write_pp  = valid & hd_ctrl.reg_write;
    assign bus.mem_to_reg_execute_pp = hd_ctrl.mem_to_reg;
    assign bus.stall_count           = stall;
    always_ff @(posedge clk or negedge rst)
        if (!rst) stall <= '0;
        else if (!bus.flush && valid && !bus.mem_ready && stall != STALL_MAX) stall <= stall + 16'd1;
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: random + directed stimulus, FIFO reference model scoreboard.
module tb_execute_pipe;
    typedef struct packed {
        logic        ld, st, me, rw;
        logic [1:0]  m2r;
        logic [31:0] alu, sd, pc, ins;
    } pl_t;
    logic clk = 0;
    logic rst = 1;
    logic mon_en = 0;
    int total = 0;
    int bad = 0;
    pl_t q[$];
    pl_t pend, last;
    logic pend_v = 0;
    logic [15:0] exp_stall = 0;
    logic [15:0] s;
    execute_pipe_if b ();
    execute_pipe dut (.clk(clk), .rst(rst), .bus(b));
    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endfunction

    // one cycle: commit last cycle's accept to the model, then drive new inputs
    task automatic cyc(input logic iv, input logic mr, input logic fl, input logic [31:0] a);
        @(posedge clk);
        if (pend_v) q.push_back(pend);
        pend_v = 0;
        #1;
        pend.ld = 1'($urandom); pend.st = 1'($urandom); pend.me = 1'($urandom); pend.rw = 1'($urandom);
        pend.m2r = 2'($urandom); pend.alu = a; pend.sd = $urandom; pend.pc = $urandom; pend.ins = $urandom;
        b.in_valid = iv; b.mem_ready = mr; b.flush = fl;
        b.Load = pend.ld; b.Store = pend.st; b.mem_en = pend.me; b.reg_write = pend.rw;
        b.mem_to_reg = pend.m2r; b.alu_result = pend.alu; b.store_data = pend.sd;
        b.pc = pend.pc; b.instruction = pend.ins;
        pend_v = iv && b.in_ready && !fl;
    endtask

    always @(negedge clk) if (mon_en) begin
        chk("out_valid", 32'(b.out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(b.in_ready), 32'(q.size() < 2));
        chk("stall_count", 32'(b.stall_count), 32'(exp_stall));
        if (q.size() != 0) last = q[0];
        chk("alu", b.alu_result_execute_pp, last.alu);
        chk("store_data", b.store_data_execute_pp, last.sd);
        chk("pc", b.pc_execute_pp, last.pc);
        chk("instr", b.instruction_execute_pp, last.ins);
        chk("mem_to_reg", 32'(b.mem_to_reg_execute_pp), 32'(last.m2r));
        chk("load", 32'(b.Load_execute_pp), 32'(q.size() != 0 && last.ld));
        chk("store", 32'(b.Store_execute_pp), 32'(q.size() != 0 && last.st));
        chk("mem_en", 32'(b.mem_en_execute_pp), 32'(q.size() != 0 && last.me));
        chk("reg_write", 32'(b.execute_reg_write_pp), 32'(q.size() != 0 && last.rw));
        if (b.flush) q.delete();
        else if (q.size() != 0) begin
            if (!b.mem_ready && exp_stall != 16'hFFFF) exp_stall++;
            if (b.mem_ready) void'(q.pop_front());
        end
    end

    initial begin
        last = '0;
        {b.in_valid, b.mem_ready, b.flush, b.Load, b.Store, b.mem_en, b.reg_write} = '0;
        {b.mem_to_reg, b.alu_result, b.store_data, b.pc, b.instruction} = '0;
        #2 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(b.out_valid), 0);
        chk("rst in_ready", 32'(b.in_ready), 1);
        chk("rst stall", 32'(b.stall_count), 0);
        chk("rst alu", b.alu_result_execute_pp, 0);
        rst = 1;
        mon_en = 1;
        // single payload, one-cycle latency
        cyc(1, 1, 0, 32'h10);
        cyc(0, 1, 0, 0);
        chk("lat out_valid", 32'(b.out_valid), 1);
        chk("lat alu", b.alu_result_execute_pp, 32'h10);
        chk("lat in_ready", 32'(b.in_ready), 1);
        // fill to TWO, refuse third, drain in order
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 2);
        cyc(1, 0, 0, 3);
        chk("full in_ready", 32'(b.in_ready), 0);
        chk("full head", b.alu_result_execute_pp, 1);
        cyc(0, 1, 0, 0);
        chk("drain1", b.alu_result_execute_pp, 1);
        cyc(0, 1, 0, 0);
        chk("drain2", b.alu_result_execute_pp, 2);
        // flush of a full buffer with a competing accept
        cyc(1, 0, 0, 4);
        cyc(1, 0, 0, 5);
        cyc(1, 0, 1, 6);
        s = exp_stall;
        cyc(0, 0, 0, 0);
        chk("flush out_valid", 32'(b.out_valid), 0);
        chk("flush in_ready", 32'(b.in_ready), 1);
        chk("flush reg_write", 32'(b.execute_reg_write_pp), 0);
        chk("flush mem_en", 32'(b.mem_en_execute_pp), 0);
        chk("flush stall", 32'(b.stall_count), 32'(s));
        // accept and release together in ONE
        cyc(1, 0, 0, 32'h11);
        cyc(1, 1, 0, 32'h55);
        cyc(0, 0, 0, 0);
        chk("swap out_valid", 32'(b.out_valid), 1);
        chk("swap in_ready", 32'(b.in_ready), 1);
        chk("swap head", b.alu_result_execute_pp, 32'h55);
        cyc(0, 1, 0, 0);
        // long stall saturates the counter
        cyc(1, 0, 0, 7);
        repeat (65540) cyc(0, 0, 0, $urandom);
        chk("stall sat", 32'(b.stall_count), 32'hFFFF);
        cyc(0, 1, 0, 0);
        repeat (3000) cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 24) == 0, $urandom);
        cyc(0, 1, 1, 0);
        // asynchronous reset while holding two payloads
        cyc(1, 0, 0, 8);
        cyc(1, 0, 0, 9);
        cyc(0, 0, 0, 0);
        chk("pre-rst out_valid", 32'(b.out_valid), 1);
        #1;
        mon_en = 0;
        rst = 0;
        #1;
        chk("arst out_valid", 32'(b.out_valid), 0);
        chk("arst in_ready", 32'(b.in_ready), 1);
        chk("arst alu", b.alu_result_execute_pp, 0);
        chk("arst instr", b.instruction_execute_pp, 0);
        chk("arst load", 32'(b.Load_execute_pp), 0);
        chk("arst mem_to_reg", 32'(b.mem_to_reg_execute_pp), 0);
        chk("arst stall", 32'(b.stall_count), 0);
        q.delete();
        pend_v = 0;
        exp_stall = 0;
        last = '0;
        @(posedge clk);
        #1;
        rst = 1;
        mon_en = 1;
        repeat (200) cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, 0, $urandom);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
